iter_shift_unit: RTL and testbench
==================================

Name: iter_shift_unit

Overview:
- Parametrised, multi-cycle shift/rotate unit; successor to the fixed two-bit left shifter on the branch-offset path.
- Shifts a WIDTH-bit operand by a run-time amount using up to STEP bit positions per clock.
- Supports logical left, logical right, arithmetic right and rotate left.
- Sits beside the ALU as a shared shift resource, with a start/busy/done handshake to the multi-cycle control unit.

Parameters:
- WIDTH, 32, operand/result width in bits. Power of two, >= 8.
- STEP, 4, maximum shift distance applied per clock. Power of two, 1 <= STEP <= WIDTH.
- SHW, clog2(WIDTH), derived localparam: width of the shift-amount port. Not overridable.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled on a rising edge only when busy==0.
- mode  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL. Latched at accept.
- shamt  input  SHW  shift amount, 0..WIDTH-1. Latched at accept.
- din  input  WIDTH  operand. Latched at accept.
- busy  output  1  high while shifting. start is ignored while high.
- done  output  1  one-cycle pulse: dout valid and newly updated.
- dout  output  WIDTH  result register. Holds its value until the next completion.
- zero  output  1  combinational, (dout == 0).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n asserted low clears state immediately, independent of clk).
- Reset values: state=IDLE, busy=0, done=0, dout=0, so zero=1. Internal work register and remaining count are cleared.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1.
- Accept: on a rising edge where start==1 and state is IDLE or DONE, latch din, mode and shamt into internal registers, and set remaining=shamt.
  - shamt==0: next state is DONE and dout<=din at that same edge.
  - otherwise: next state is SHIFT.
- SHIFT, each edge:
  - k = min(STEP, remaining).
  - Apply a k-bit shift to the work register: SLL fills zeros at the LSBs; SRL fills zeros at the MSBs; SRA replicates the latched operand's MSB; ROL moves bits shifted out of the MSB into the LSBs.
  - remaining -= k.
  - If the new remaining is 0: dout<=shifted value, next state DONE. Otherwise stay in SHIFT.
- Latency: N = ceil(shamt/STEP) SHIFT edges after the accept edge.
  - done is high in the cycle following edge N after accept (N=0 for shamt=0).
  - busy is high for exactly N cycles.
- DONE: lasts one cycle.
  - Next edge with start==1 is a new accept (back-to-back allowed; done drops unless the new request has shamt==0, in which case done stays high for a second consecutive cycle with the new dout).
  - Otherwise next state is IDLE.
- start while busy==1 is ignored: no queueing, latched operands and result unaffected.
- din/mode/shamt changes after accept have no effect on the operation in flight.
- Arithmetic: SRA by any amount equals a signed >>> of the latched operand. ROL is modulo WIDTH. There are no out-of-range amounts, since shamt is SHW bits.
- reset_n low mid-operation aborts immediately to reset values. No done pulse for the aborted request.
- dout changes only on a completion edge or on reset.

Test Plan:
- WIDTH=32, STEP=4: SLL, din=0x0000_0001, shamt=2 -> N=1, busy high 1 cycle, done pulse, dout=0x0000_0004, zero=0.
- SRA, din=0x8000_0000, shamt=31 -> busy high 8 cycles, then done, dout=0xFFFF_FFFF. Same with SRL -> dout=0x0000_0001.
- ROL, din=0x8000_0001, shamt=4 -> dout=0x0000_0018 after 1 busy cycle. Then ROL din=0xF000_0000, shamt=31 -> dout=0x7800_0000.
- shamt=0, SLL din=0x1234_5678 -> no busy cycle, done in the cycle after accept, dout=0x1234_5678. Then SLL din=0x0000_0000 -> zero=1.
- Accept SRL shamt=16; pulse start with new operands on busy cycle 2 -> ignored, result is that of the first request, 4 busy cycles. Assert start again during the DONE cycle -> back-to-back accept, correct second result.
- Accept SLL shamt=20, drop reset_n low mid-cycle after 2 shift edges -> busy, done and dout clear asynchronously, zero=1, no done pulse. After release, a new request completes normally.

Source files
------------

// File: rtl/iter_shift_unit.sv
// ----------------------------------------------------------------------------
// iter_shift_unit
//
// Multi-cycle shift/rotate unit shared beside the ALU. An operand is shifted
// by a run-time amount, applying at most STEP bit positions per clock, so a
// narrow shifter is reused over several cycles instead of building a full
// WIDTH-wide barrel shifter.
//
// Operations (mode):
//   2'b00 SLL  logical left, zeros enter at the LSBs
//   2'b01 SRL  logical right, zeros enter at the MSBs
//   2'b10 SRA  arithmetic right, the operand's sign bit enters at the MSBs
//   2'b11 ROL  rotate left, bits leaving the MSB re-enter at the LSB
//
// Handshake:
//   A request is accepted on a rising edge with start=1 while the unit is
//   idle or presenting a result (busy=0). busy is high for exactly
//   ceil(shamt/STEP) cycles, then done pulses for one cycle with the new
//   result on dout. shamt=0 completes on the accept edge itself. A new
//   request may be accepted in the done cycle (back-to-back).
//
// Ports:
//   clk      in   1      rising-edge system clock
//   reset_n  in   1      asynchronous active-low reset
//   start    in   1      request, only honoured while busy=0
//   mode     in   2      operation select, latched at accept
//   shamt    in   SHW    shift amount 0..WIDTH-1, latched at accept
//   din      in   WIDTH  operand, latched at accept
//   busy     out  1      high while shifting
//   done     out  1      one-cycle completion pulse
//   dout     out  WIDTH  result register, held until the next completion
//   zero     out  1      (dout == 0), combinational from the result register
// ----------------------------------------------------------------------------
module iter_shift_unit #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             zero
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // STEP may equal WIDTH, which does not fit in SHW bits, so the per-step
  // limit is compared in SHW+1 bits.
  localparam logic [SHW:0] STEP_EXT = (SHW+1)'(STEP);

  state_t           state_r;
  logic [WIDTH-1:0] work_r;
  logic [SHW-1:0]   rem_r;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] dout_r;
  logic             busy_r;
  logic             done_r;

  logic [SHW-1:0]   step_amt_s;
  logic [SHW-1:0]   rem_next_s;
  logic [WIDTH-1:0] step_res_s;

  // One partial shift of v by amt positions. For SRA the work register's MSB
  // is the latched operand's sign bit at every step (a right arithmetic shift
  // never alters the MSB), so a signed shift replicates the original sign.
  // For ROL the bits wrapping around come from a right shift by
  // (WIDTH - amt), which in SHW-bit arithmetic is simply -amt; amt=0 gives
  // v | v = v.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] v,
    input logic [1:0]       m,
    input logic [SHW-1:0]   amt
  );
    logic [SHW-1:0] back_amt;
    back_amt = ~amt + {{(SHW-1){1'b0}}, 1'b1};
    case (m)
      MODE_SLL: shift_step = v << amt;
      MODE_SRL: shift_step = v >> amt;
      MODE_SRA: shift_step = $unsigned($signed(v) >>> amt);
      MODE_ROL: shift_step = (v << amt) | (v >> back_amt);
      default:  shift_step = v;
    endcase
  endfunction

  // Per-cycle step size k = min(STEP, remaining) and the shifted work value.
  always_comb begin
    step_amt_s = rem_r;
    if ({1'b0, rem_r} > STEP_EXT) begin
      step_amt_s = STEP_EXT[SHW-1:0];
    end else begin
      step_amt_s = rem_r;
    end
    rem_next_s = rem_r - step_amt_s;
    step_res_s = shift_step(work_r, mode_r, step_amt_s);
  end

  // Control FSM with registered handshake outputs and the result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      work_r  <= '0;
      rem_r   <= '0;
      mode_r  <= 2'b00;
      dout_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mode_r <= mode;
            work_r <= din;
            rem_r  <= shamt;
            if (shamt == '0) begin
              // Nothing to shift: the operand is the result right away.
              dout_r  <= din;
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_SHIFT;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end

        ST_SHIFT: begin
          // start is deliberately not looked at here: requests while busy
          // are dropped, not queued.
          work_r <= step_res_s;
          rem_r  <= rem_next_s;
          if (rem_next_s == '0) begin
            dout_r  <= step_res_s;
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign dout = dout_r;
  assign zero = (dout_r == '0);

endmodule

// File: tb/tb_iter_shift_unit.sv
// ----------------------------------------------------------------------------
// tb_iter_shift_unit
//
// Directed self-checking bench for iter_shift_unit (WIDTH=32, STEP=4).
// Expected results and busy-cycle counts are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_iter_shift_unit;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int SHW   = 5;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [1:0]       mode;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             zero;

  int n_checks;
  int n_fail;

  iter_shift_unit #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mode    (mode),
    .shamt   (shamt),
    .din     (din),
    .busy    (busy),
    .done    (done),
    .dout    (dout),
    .zero    (zero)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports.
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // From the current sample point, wait until done, counting busy cycles.
  task automatic wait_done(output int nb, output bit seen);
    int cyc;
    nb   = 0;
    cyc  = 0;
    seen = 1'b0;
    while (!done && cyc < 200) begin
      if (busy) nb++;
      @(posedge clk); #1;
      cyc++;
    end
    seen = done;
  endtask

  // Issue one request, scramble the inputs after accept, wait for the result.
  // Returns at the sample point of the done cycle.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp, input int exp_busy);
    int nb;
    bit seen;
    @(negedge clk);
    start = 1'b1; mode = m; din = d; shamt = s;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; din = ~d; shamt = ~s;
    wait_done(nb, seen);
    check_eq({tag, "_done"}, 32'(seen), 32'd1);
    check_eq({tag, "_busycyc"}, 32'(nb), 32'(exp_busy));
    check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check_eq({tag, "_dout"}, dout, exp);
    check_eq({tag, "_zero"}, 32'(zero), 32'(exp == 32'h0));
  endtask

  // After a done cycle with no new start: done drops, result held.
  task automatic idle_check(input string tag, input logic [31:0] exp);
    @(posedge clk); #1;
    check_eq({tag, "_done_drop"}, 32'(done), 32'd0);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_hold"}, dout, exp);
  endtask

  initial begin
    int nb;
    bit seen;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    mode     = 2'b00;
    shamt    = 5'd0;
    din      = 32'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_dout", dout, 32'h0);
    check_eq("rst_zero", 32'(zero), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic operations.
    run_op("sll2", 2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004, 1);
    idle_check("sll2", 32'h0000_0004);
    run_op("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 8);
    idle_check("sra31", 32'hFFFF_FFFF);
    run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 8);
    idle_check("srl31", 32'h0000_0001);
    run_op("rol4", 2'b11, 32'h8000_0001, 5'd4, 32'h0000_0018, 1);
    idle_check("rol4", 32'h0000_0018);
    run_op("rol31", 2'b11, 32'hF000_0000, 5'd31, 32'h7800_0000, 8);
    idle_check("rol31", 32'h7800_0000);

    // shamt=0, then a back-to-back shamt=0 of zero: done stays high.
    run_op("sh0", 2'b00, 32'h1234_5678, 5'd0, 32'h1234_5678, 0);
    run_op("sh0z", 2'b00, 32'h0000_0000, 5'd0, 32'h0000_0000, 0);
    idle_check("sh0z", 32'h0000_0000);

    // Start while busy is ignored; start during done is a new accept.
    @(negedge clk);
    start = 1'b1; mode = 2'b01; din = 32'hABCD_1234; shamt = 5'd16;
    @(posedge clk); #1;                         // busy cycle 1
    start = 1'b0; din = 32'h0; shamt = 5'd0;
    @(posedge clk); #1;                         // busy cycle 2
    @(negedge clk);
    start = 1'b1; mode = 2'b00; din = 32'hFFFF_FFFF; shamt = 5'd1;
    @(posedge clk); #1;                         // busy cycle 3
    start = 1'b0;
    wait_done(nb, seen);
    check_eq("ign_done", 32'(seen), 32'd1);
    check_eq("ign_busycyc", 32'(nb + 2), 32'd4);
    check_eq("ign_dout", dout, 32'h0000_ABCD);
    run_op("b2b", 2'b00, 32'h0000_00FF, 5'd8, 32'h0000_FF00, 2);
    idle_check("b2b", 32'h0000_FF00);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; din = 32'h0000_0001; shamt = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_dout", dout, 32'h0);
    check_eq("arst_zero", 32'(zero), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check_eq("arst_no_done", 32'(done), 32'd0);
    end
    check_eq("arst_dout_after", dout, 32'h0);

    // Normal operation after reset release.
    run_op("post_sra", 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, 1);
    idle_check("post_sra", 32'hF800_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
